decodificador_teclado: RTL and testbench

//  Consumes bytes from the PS/2 serial reader (scan_code + end_scan, PS/2 clock domain) in the system clock domain.

---
 rtl/decodificador_teclado.sv | 236 +++++++++++++++++++++++
 tb/tb_decodificador_teclado.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_teclado.sv
// PS/2 Set-2 key decoder: resyncs end_scan, strips E0/F0 prefixes into key events,
// and buffers ASCII for dialling keys in a small valid/ready FIFO.
module decodificador_teclado #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       end_scan,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e            state_q, state_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              s1_q, s2_q, s3_q;
    logic              rise;
    logic              key_valid_q, key_valid_d;
    logic [7:0]        key_code_q, key_code_d;
    logic              key_ext_q, key_ext_d;
    logic              key_break_q, key_break_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [7:0]        ascii_out_q, ascii_out_d;
    logic              overflow_q, overflow_d;
    logic              full, rd_en, wr_en, push;
    logic [8:0]        map;

    // Returns {hit, character}; only make codes are ever looked up.
    function automatic logic [8:0] map_ascii(input logic [7:0] code, input logic ext);
        logic [8:0] r;
        r = 9'h000;
        if (ext) begin
            case (code)
                8'h5A:   r = {1'b1, 8'h0D};
                8'h4A:   r = {1'b1, 8'h2F};
                default: r = 9'h000;
            endcase
        end else begin
            case (code)
                8'h16, 8'h69: r = {1'b1, 8'h31};
                8'h1E, 8'h72: r = {1'b1, 8'h32};
                8'h26, 8'h7A: r = {1'b1, 8'h33};
                8'h25, 8'h6B: r = {1'b1, 8'h34};
                8'h2E, 8'h73: r = {1'b1, 8'h35};
                8'h36, 8'h74: r = {1'b1, 8'h36};
                8'h3D, 8'h6C: r = {1'b1, 8'h37};
                8'h3E, 8'h75: r = {1'b1, 8'h38};
                8'h46, 8'h7D: r = {1'b1, 8'h39};
                8'h45, 8'h70: r = {1'b1, 8'h30};
                8'h7C: r = {1'b1, 8'h2A};
                8'h5A: r = {1'b1, 8'h0D};
                8'h66: r = {1'b1, 8'h08};
                8'h29: r = {1'b1, 8'h20};
                8'h1C: r = {1'b1, 8'h41};
                8'h32: r = {1'b1, 8'h42};
                8'h21: r = {1'b1, 8'h43};
                8'h23: r = {1'b1, 8'h44};
                8'h24: r = {1'b1, 8'h45};
                8'h2B: r = {1'b1, 8'h46};
                8'h34: r = {1'b1, 8'h47};
                8'h33: r = {1'b1, 8'h48};
                8'h43: r = {1'b1, 8'h49};
                8'h3B: r = {1'b1, 8'h4A};
                8'h42: r = {1'b1, 8'h4B};
                8'h4B: r = {1'b1, 8'h4C};
                8'h3A: r = {1'b1, 8'h4D};
                8'h31: r = {1'b1, 8'h4E};
                8'h44: r = {1'b1, 8'h4F};
                8'h4D: r = {1'b1, 8'h50};
                8'h15: r = {1'b1, 8'h51};
                8'h2D: r = {1'b1, 8'h52};
                8'h1B: r = {1'b1, 8'h53};
                8'h2C: r = {1'b1, 8'h54};
                8'h3C: r = {1'b1, 8'h55};
                8'h2A: r = {1'b1, 8'h56};
                8'h1D: r = {1'b1, 8'h57};
                8'h22: r = {1'b1, 8'h58};
                8'h35: r = {1'b1, 8'h59};
                8'h1A: r = {1'b1, 8'h5A};
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    assign rise = s2_q & ~s3_q;

    // Prefix parser and timeout.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        if (rise) begin
            tmo_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (scan_code == 8'hE0) begin
                        state_d = StExt;
                    end else if (scan_code == 8'hF0) begin
                        state_d = StBrk;
                    end else if (!(scan_code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE,
                                                     8'h00, 8'hFF, 8'hE1})) begin
                        key_valid_d = 1'b1;
                        key_code_d  = scan_code;
                        key_ext_d   = 1'b0;
                        key_break_d = 1'b0;
                    end
                end
                StExt: begin
                    if (scan_code == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (scan_code != 8'hE0) begin
                        key_valid_d = 1'b1;
                        key_code_d  = scan_code;
                        key_ext_d   = 1'b1;
                        key_break_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                StBrk, StExtBrk: begin
                    if (scan_code == 8'hE0) begin
                        state_d = StExt;
                    end else if (scan_code != 8'hF0) begin
                        key_valid_d = 1'b1;
                        key_code_d  = scan_code;
                        key_ext_d   = (state_q == StExtBrk);
                        key_break_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                state_d = StIdle;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    // ASCII FIFO; a full FIFO still takes a write when the head leaves in the same cycle.
    always_comb begin
        map        = map_ascii(key_code_d, key_ext_d);
        push       = key_valid_d & ~key_break_d & map[8];
        full       = (count_q == CntW'(FIFO_DEPTH));
        rd_en      = (count_q != '0) & ascii_ready;
        wr_en      = push & (~full | rd_en);
        overflow_d = overflow_q | (push & full & ~rd_en);
        mem_d      = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = map[7:0];
        end
        wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
        rd_ptr_d = rd_ptr_q + PtrW'(rd_en);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ascii_out_d = (count_d != '0) ? mem_d[rd_ptr_d] : ascii_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Sync chain preset high so a level already present is not seen as a new byte.
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s3_q        <= 1'b1;
            state_q     <= StIdle;
            tmo_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ascii_out_q <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            s1_q        <= end_scan;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_break_q <= key_break_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ascii_out_q <= ascii_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_break   = key_break_q;
    assign ascii_out   = ascii_out_q;
    assign ascii_valid = (count_q != '0);
    assign fifo_full   = (count_q == CntW'(FIFO_DEPTH));
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_decodificador_teclado.sv
// Directed bench for decodificador_teclado: prefixes, ASCII FIFO, overflow, timeout, reset.
module tb_decodificador_teclado;

    localparam int unsigned Depth = 4;
    localparam int unsigned Tmo   = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       end_scan = 1'b0;
    logic       ascii_ready = 1'b0;
    logic       key_valid, key_ext, key_break, ascii_valid, fifo_full, overflow;
    logic [7:0] key_code, ascii_out;

    int checks = 0;
    int errors = 0;
    int kv_count = 0;
    int kv_base;
    logic       kv_s, ke_s, kb_s;
    logic [7:0] kc_s;

    decodificador_teclado #(.FIFO_DEPTH(Depth), .TIMEOUT_CYC(Tmo)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_code  (scan_code),
        .end_scan   (end_scan),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .ascii_out  (ascii_out),
        .ascii_valid(ascii_valid),
        .ascii_ready(ascii_ready),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (key_valid) kv_count <= kv_count + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Byte handshake: E0/E1/E2 edges after raising end_scan; fields sampled #1 after E2.
    task automatic send_byte(input logic [7:0] b, input logic rdy_at_rise);
        @(negedge clk);
        scan_code = b;
        end_scan  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        if (rdy_at_rise) ascii_ready = 1'b1;
        @(posedge clk);
        #1;
        ascii_ready = 1'b0;
        kv_s = key_valid;
        kc_s = key_code;
        ke_s = key_ext;
        kb_s = key_break;
        repeat (2) @(negedge clk);
        end_scan = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(ascii_valid), 32'd1);
        chk({tag, "_char"}, 32'(ascii_out), 32'(exp));
        ascii_ready = 1'b1;
        @(posedge clk);
        #1;
        ascii_ready = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_kv", 32'(key_valid), 32'd0);
        chk("rst_av", 32'(ascii_valid), 32'd0);
        chk("rst_ascii", 32'(ascii_out), 32'h00);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // 1: plain make of '1'
        @(negedge clk);
        scan_code = 8'h16;
        end_scan  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t1_kv", 32'(key_valid), 32'd1);
        chk("t1_code", 32'(key_code), 32'h16);
        chk("t1_ext", 32'(key_ext), 32'd0);
        chk("t1_brk", 32'(key_break), 32'd0);
        chk("t1_av", 32'(ascii_valid), 32'd1);
        chk("t1_ascii", 32'(ascii_out), 32'h31);
        @(posedge clk);
        #1;
        chk("t1_kv_pulse", 32'(key_valid), 32'd0);
        end_scan = 1'b0;
        repeat (6) @(negedge clk);
        pop("t1_pop", 8'h31);

        // 2: break codes yield events but no characters
        send_byte(8'hF0, 1'b0);
        chk("t2_f0_kv", 32'(kv_s), 32'd0);
        send_byte(8'h16, 1'b0);
        chk("t2_kv", 32'(kv_s), 32'd1);
        chk("t2_code", 32'(kc_s), 32'h16);
        chk("t2_brk", 32'(kb_s), 32'd1);
        chk("t2_ext", 32'(ke_s), 32'd0);
        chk("t2_av", 32'(ascii_valid), 32'd0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h5A, 1'b0);
        chk("t2x_kv", 32'(kv_s), 32'd1);
        chk("t2x_code", 32'(kc_s), 32'h5A);
        chk("t2x_ext", 32'(ke_s), 32'd1);
        chk("t2x_brk", 32'(kb_s), 32'd1);
        chk("t2x_av", 32'(ascii_valid), 32'd0);

        // Map spot checks: extended enter/slash, letter, keypad, enter, unmapped
        send_byte(8'hE0, 1'b0);
        send_byte(8'h5A, 1'b0);
        chk("m_ext_enter_ext", 32'(ke_s), 32'd1);
        pop("m_ext_enter", 8'h0D);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h4A, 1'b0);
        pop("m_slash", 8'h2F);
        send_byte(8'h1C, 1'b0);
        pop("m_A", 8'h41);
        send_byte(8'h1A, 1'b0);
        pop("m_Z", 8'h5A);
        send_byte(8'h69, 1'b0);
        pop("m_kp1", 8'h31);
        send_byte(8'h7C, 1'b0);
        pop("m_star", 8'h2A);
        send_byte(8'h05, 1'b0);
        chk("m_unmapped_kv", 32'(kv_s), 32'd1);
        chk("m_unmapped_av", 32'(ascii_valid), 32'd0);

        // 3: overflow with no consumer
        do_reset();
        send_byte(8'h16, 1'b0);
        send_byte(8'h1E, 1'b0);
        send_byte(8'h26, 1'b0);
        send_byte(8'h25, 1'b0);
        chk("t3_full", 32'(fifo_full), 32'd1);
        chk("t3_ovf_pre", 32'(overflow), 32'd0);
        send_byte(8'h2E, 1'b0);
        chk("t3_ovf", 32'(overflow), 32'd1);
        pop("t3_p0", 8'h31);
        pop("t3_p1", 8'h32);
        pop("t3_p2", 8'h33);
        pop("t3_p3", 8'h34);
        @(negedge clk);
        chk("t3_empty", 32'(ascii_valid), 32'd0);
        chk("t3_hold", 32'(ascii_out), 32'h34);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: full FIFO with a read in the write cycle
        do_reset();
        send_byte(8'h16, 1'b0);
        send_byte(8'h1E, 1'b0);
        send_byte(8'h26, 1'b0);
        send_byte(8'h25, 1'b0);
        send_byte(8'h36, 1'b1);
        chk("t4_full", 32'(fifo_full), 32'd1);
        chk("t4_ovf", 32'(overflow), 32'd0);
        pop("t4_p0", 8'h32);
        pop("t4_p1", 8'h33);
        pop("t4_p2", 8'h34);
        pop("t4_p3", 8'h36);

        // 5: E0 prefix times out
        send_byte(8'hE0, 1'b0);
        repeat (Tmo + 5) @(negedge clk);
        send_byte(8'h16, 1'b0);
        chk("t5_kv", 32'(kv_s), 32'd1);
        chk("t5_ext", 32'(ke_s), 32'd0);
        pop("t5_pop", 8'h31);

        // Reset mid-prefix discards the prefix
        send_byte(8'hE0, 1'b0);
        do_reset();
        send_byte(8'h5A, 1'b0);
        chk("rp_ext", 32'(ke_s), 32'd0);
        pop("rp_pop", 8'h0D);

        // 6: end_scan high across reset release, then AA
        @(negedge clk);
        kv_base   = kv_count;
        reset     = 1'b1;
        scan_code = 8'h16;
        end_scan  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_no_event", 32'(kv_count - kv_base), 32'd0);
        chk("t6_av", 32'(ascii_valid), 32'd0);
        end_scan = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'hAA, 1'b0);
        chk("t6_aa_kv", 32'(kv_s), 32'd0);
        chk("t6_aa_total", 32'(kv_count - kv_base), 32'd0);
        send_byte(8'h16, 1'b0);
        chk("t6_after_kv", 32'(kv_s), 32'd1);
        chk("t6_after_ext", 32'(ke_s), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
